// File: rtl/rr_mux_n_pkg.sv
// mux_pkg: shared types and helpers for the rr_mux_n multiplexer slice.
//   mux_mode_t   - channel selection mode encoding (3 is reserved, treated as MODE_RR)
//   rr_ptr_reset - round-robin pointer value after reset, so channel 0 is searched first
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_RR    = 2'd0,
        MODE_PRIO  = 2'd1,
        MODE_FORCE = 2'd2
    } mux_mode_t;

    // Search starts at ptr+1, so parking the pointer on N-1 makes channel 0 first.
    function automatic int unsigned rr_ptr_reset(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_mux_n_arbiter.sv
// rr_arbiter: purely combinational grant selection for rr_mux_n.
//   req     [N]  per-channel request
//   ptr     [SW] last round-robin winner; the search starts at (ptr+1) mod N
//   mode    [2]  0/3 round-robin, 1 fixed priority, 2 forced select
//   sel     [SW] forced channel index (no grant if sel >= N)
//   grant   [N]  one-hot grant, or zero
//   gnt_idx [SW] index of the granted channel (0 when gnt_any=0)
//   gnt_any      any channel granted
import mux_pkg::*;

module rr_arbiter #(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sel,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    int unsigned idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        case (mode)
            MODE_PRIO: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!gnt_any && req[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SW'(i);
                    end
                end
            end
            MODE_FORCE: begin
                // Matching sel against each legal index means sel >= N never grants.
                for (int unsigned i = 0; i < N; i++) begin
                    if (SW'(i) == sel && req[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SW'(i);
                    end
                end
            end
            default: begin
                // Offsets 1..N from ptr; modulo keeps the wrap correct for any N.
                for (int unsigned k = 1; k <= N; k++) begin
                    idx = (32'(ptr) + k) % unsigned'(N);
                    if (!gnt_any && req[idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SW'(idx);
                    end
                end
            end
        endcase
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel, W-bit registered multiplexer with valid/ready handshake.
//   clk, rst       rising-edge clock, synchronous active-high reset
//   mode [2]       0/3 round-robin, 1 fixed priority, 2 forced select
//   sel  [SW]      channel used in forced mode
//   in_data [N][W] per-channel data; in_valid/in_ready per-channel handshake
//   out_data [W]   registered selected word; out_valid/out_ready consumer handshake
//   out_sel [SW]   channel that supplied out_data
import mux_pkg::*;

module rr_mux_n #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] sel,
    input  logic [W-1:0]  in_data [N],
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    output logic [SW-1:0] out_sel,
    input  logic          out_ready
);

    logic [SW-1:0] ptr;
    logic [N-1:0]  grant;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic          load;
    logic          xfer;
    logic          rr_mode;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .mode    (mode),
        .sel     (sel),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Register is free when empty or being drained this cycle: full throughput.
    assign load     = ~out_valid | out_ready;
    assign in_ready = (load && !rst) ? grant : '0;
    // A grant only exists for a valid requester, so this is the transfer strobe.
    assign xfer     = load & gnt_any & ~rst;
    assign rr_mode  = (mode != MODE_PRIO) && (mode != MODE_FORCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SW'(rr_ptr_reset(N));
        end else if (xfer) begin
            out_data  <= in_data[gnt_idx];
            out_sel   <= gnt_idx;
            out_valid <= 1'b1;
            if (rr_mode) begin
                ptr <= gnt_idx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed self-checking bench for rr_mux_n (N=4, W=8).
module tb_rr_mux_n;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [SW-1:0] out_sel;
    logic          out_ready;

    int checks   = 0;
    int failures = 0;

    rr_mux_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        logic [1:0] alt_seq [4];
        logic [3:0] alt_rdy [4];
        rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        alt_seq = '{2'd1, 2'd3, 2'd1, 2'd3};
        alt_rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        in_data[0] = 8'h00;
        in_data[1] = 8'h11;
        in_data[2] = 8'h22;
        in_data[3] = 8'h33;
        rst       = 1'b1;
        mode      = 2'd0;
        sel       = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;

        // Reset state; in_ready held low during reset even with requests pending
        step();
        step();
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset_in_ready", 32'(in_ready), 32'h0);

        // Round-robin across all four channels
        rst = 1'b0;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("rr%0d", i), 1'b1, 8'(8'h11 * rr_seq[i]), rr_seq[i]);
        end

        // Round-robin alternates between channels 1 and 3 (ptr now 0)
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt%0d_ready", i), 32'(in_ready), 32'(alt_rdy[i]));
            step();
            check($sformatf("alt%0d_sel", i), 32'(out_sel), 32'(alt_seq[i]));
        end

        // Fixed priority: lowest requester wins repeatedly, ptr untouched (stays 3)
        mode     = 2'd1;
        in_valid = 4'b1110;
        #1;
        check("prio_ready", 32'(in_ready), 32'b0010);
        step();
        check_out("prio0", 1'b1, 8'h11, 2'd1);
        step();
        check_out("prio1", 1'b1, 8'h11, 2'd1);
        in_valid = 4'b1100;
        #1;
        check("prio_drop_ready", 32'(in_ready), 32'b0100);
        step();
        check_out("prio2", 1'b1, 8'h22, 2'd2);

        // Forced select
        mode     = 2'd2;
        sel      = 2'd2;
        in_valid = 4'b0111;
        #1;
        check("force_ready", 32'(in_ready), 32'b0100);
        step();
        check_out("force0", 1'b1, 8'h22, 2'd2);
        sel = 2'd3;
        #1;
        check("force_blk_ready", 32'(in_ready), 32'h0);
        step();
        check_out("force_drain", 1'b0, 8'h22, 2'd2);

        // Backpressure: ptr is still 3 from the alternating phase
        mode     = 2'd0;
        in_valid = 4'b1111;
        #1;
        check("bp_first_ready", 32'(in_ready), 32'b0001);
        step();
        check_out("bp_load", 1'b1, 8'h00, 2'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_ready", i), 32'(in_ready), 32'h0);
            step();
            check_out($sformatf("bp%0d", i), 1'b1, 8'h00, 2'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0010);
        step();
        check_out("bp_release", 1'b1, 8'h11, 2'd1);

        // Reset while holding 0x5A
        mode       = 2'd2;
        sel        = 2'd2;
        in_data[2] = 8'h5A;
        in_valid   = 4'b0100;
        step();
        check_out("pre_rst", 1'b1, 8'h5A, 2'd2);
        rst = 1'b1;
        step();
        check_out("mid_rst", 1'b0, 8'h00, 2'd0);
        rst        = 1'b0;
        mode       = 2'd0;
        in_data[2] = 8'h22;
        in_valid   = 4'b1111;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'b0001);
        step();
        check_out("post_rst", 1'b1, 8'h00, 2'd0);

        // Reserved mode 3 continues round-robin from ptr=0
        mode = 2'd3;
        #1;
        check("mode3_ready", 32'(in_ready), 32'b0010);
        step();
        check_out("mode3", 1'b1, 8'h11, 2'd1);

        // No requesters: register drains, nothing loads
        in_valid = 4'b0000;
        step();
        check_out("idle", 1'b0, 8'h11, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
